// File: rtl/bht_ckpt_writer.sv
`default_nettype none
// ============================================================================
//  Module      : bht_ckpt_writer
//  Description : Walks every BHT row through a combinational read port, packs
//                8 rows per 64-bit doubleword and stores each doubleword to
//                the D-cache store port starting at a CSR-supplied base.
//                Pulses done_o after the last store.
//                Optional macro BHT_CKPT_SKIP_ZERO_EN: all-zero doublewords
//                are not stored (address still advances).
//  Revision    : 1.0 - initial release
// ============================================================================

package bht_ckpt_pkg;
    localparam int unsigned DCACHE_INDEX_WIDTH = 12;
    localparam int unsigned DCACHE_TAG_WIDTH   = 44;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [63:0]                   data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [7:0]                    data_be;
        logic [1:0]                    data_size;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;
endpackage

module bht_ckpt_writer
    import bht_ckpt_pkg::*;
#(
    parameter int unsigned NR_ROWS         = 512,
    parameter int unsigned INSTR_PER_FETCH = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    input  logic                          abort_i,
    input  logic [63:0]                   base_addr_i,
    output logic [$clog2(NR_ROWS)-1:0]    row_addr_o,
    input  logic [INSTR_PER_FETCH*3-1:0]  row_data_i,
    output dcache_req_i_t                 dcache_req_o,
    input  logic                          dcache_gnt_i,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int unsigned ROW_W   = $clog2(NR_ROWS);
    localparam int unsigned ENTRY_W = INSTR_PER_FETCH * 3;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GATHER = 2'd1;
    localparam logic [1:0] S_STORE  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [63:0]      word_q, word_d;
    logic [63:0]      addr_q, addr_d;
    logic [7:0]       w_row_byte;
    logic             w_skip;
    logic             w_store_ok;

`ifdef BHT_CKPT_SKIP_ZERO_EN
    // An all-zero doubleword is not worth a store; it completes on its own.
    assign w_skip = (word_q == 64'd0);
`else
    assign w_skip = 1'b0;
`endif

    // The current STORE cycle retires its doubleword (granted or skipped).
    assign w_store_ok = dcache_gnt_i | w_skip;

    // Next-state, row counter, word packing and address advance.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        word_d     = word_q;
        addr_d     = addr_q;
        w_row_byte = 8'd0;
        w_row_byte[ENTRY_W-1:0] = row_data_i;
        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    addr_d  = base_addr_i & ~64'h7;
                    row_d   = '0;
                    word_d  = 64'd0;
                    state_d = S_GATHER;
                end
            end
            S_GATHER: begin
                if (abort_i) begin
                    row_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    word_d[{row_q[2:0], 3'b000} +: 8] = w_row_byte;
                    row_d = row_q + 1'b1;
                    if (row_q[2:0] == 3'd7) begin
                        state_d = S_STORE;
                    end
                end
            end
            S_STORE: begin
                // A grant coinciding with abort still counts as a completed store.
                if (w_store_ok) begin
                    addr_d = addr_q + 64'd8;
                    word_d = 64'd0;
                end
                if (abort_i) begin
                    row_d   = '0;
                    state_d = S_IDLE;
                end else if (w_store_ok) begin
                    state_d = (row_q == '0) ? S_DONE : S_GATHER;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            word_q  <= 64'd0;
            addr_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
        end
    end

    // Store request is driven only in STORE; the bus is all-zero otherwise.
    always_comb begin
        dcache_req_o = '0;
        if (state_q == S_STORE && !w_skip) begin
            dcache_req_o.data_req      = 1'b1;
            dcache_req_o.data_we       = 1'b1;
            dcache_req_o.data_be       = 8'hFF;
            dcache_req_o.data_size     = 2'b11;
            dcache_req_o.data_wdata    = word_q;
            dcache_req_o.address_index = addr_q[DCACHE_INDEX_WIDTH-1:0];
            dcache_req_o.address_tag   = addr_q[DCACHE_INDEX_WIDTH+DCACHE_TAG_WIDTH-1:DCACHE_INDEX_WIDTH];
        end
    end

    assign row_addr_o = row_q;
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE) && !abort_i;

endmodule

`default_nettype wire

// File: tb/tb_bht_ckpt_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bht_ckpt_writer
//  Description : Scoreboard bench for bht_ckpt_writer (NR_ROWS=16). Expected
//                stores and completion times are produced from a reference
//                model of the checkpoint layout; a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bht_ckpt_writer;
    import bht_ckpt_pkg::*;

    localparam int NR  = 16;
    localparam int NW  = NR / 8;
    localparam int EW  = 6;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] d;
    } exp_t;

    logic                   clk;
    logic                   rst_n;
    logic                   start;
    logic                   abort;
    logic [63:0]            base_addr;
    logic [$clog2(NR)-1:0]  row_addr;
    logic [EW-1:0]          row_data;
    dcache_req_i_t          req;
    logic                   gnt;
    logic                   busy;
    logic                   done;

    logic [EW-1:0] bht [NR];
    assign row_data = bht[row_addr];

    bht_ckpt_writer #(.NR_ROWS(NR), .INSTR_PER_FETCH(2)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .abort_i      (abort),
        .base_addr_i  (base_addr),
        .row_addr_o   (row_addr),
        .row_data_i   (row_data),
        .dcache_req_o (req),
        .dcache_gnt_i (gnt),
        .busy_o       (busy),
        .done_o       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    int   exp_done[$];
    int   accept_cyc = 0;
    int   run_id = 0;
    int   first_stall = 0;
    int   max_stall = 0;
    int   stall_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Grant driver: stalls the first store of a run by first_stall cycles,
    // later stores by a random 0..max_stall cycles.
    initial begin
        int  seen_run;
        int  stall_left;
        bit  first_pend;
        bit  prev_rq;
        seen_run = 0; stall_left = 0; first_pend = 0; prev_rq = 0;
        gnt = 1'b0;
        forever begin
            @(negedge clk);
            if (seen_run != run_id) begin
                seen_run    = run_id;
                stall_left  = first_stall;
                stall_total = 0;
                first_pend  = 1;
            end
            if (req.data_req) begin
                if (!prev_rq) begin
                    if (first_pend) first_pend = 0;
                    else stall_left = $urandom_range(0, max_stall);
                end
                if (stall_left > 0) begin
                    gnt = 1'b0;
                    stall_left--;
                    stall_total++;
                end else begin
                    gnt = 1'b1;
                end
            end else begin
                gnt = 1'b0;
            end
            prev_rq = req.data_req;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: compares every presented store and every done pulse.
    initial begin
        dcache_req_i_t last;
        bit            last_stalled;
        exp_t          e;
        last = '0; last_stalled = 0;
        forever begin
            @(negedge clk);
            #1;
            if (req.data_req) begin
                check("ctrl", {54'd0, req.data_we, req.data_be, req.data_size, req.kill_req, req.tag_valid},
                      {54'd0, 1'b1, 8'hFF, 2'b11, 1'b0, 1'b0});
                if (last_stalled) check("stable", 64'(req == last), 64'd1);
                if (gnt) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_store", {8'd0, req.address_tag, req.address_index}, 64'hDEAD);
                    end else begin
                        e = exp_q.pop_front();
                        check("addr", {8'd0, req.address_tag, req.address_index}, {8'd0, e.a[55:0]});
                        check("wdata", req.data_wdata, e.d);
                    end
                end
                last = req;
                last_stalled = !gnt;
            end else begin
                check("bus_idle", 64'(req == '0), 64'd1);
                last_stalled = 0;
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 64'(cyc), 64'hFFFF);
                end else begin
                    void'(exp_done.pop_front());
                    check("done_time", 64'(cyc), 64'(accept_cyc + NW * 9 + 1 + stall_total));
                end
            end
        end
    end

    // Reference: layout of checkpoint words and which of them hit memory.
    task automatic push_expected(input logic [63:0] base);
        logic [63:0] w;
        for (int k = 0; k < NW; k++) begin
            w = 64'd0;
            for (int j = 0; j < 8; j++) w[8*j +: 8] = {2'b00, bht[8*k + j]};
`ifdef BHT_CKPT_SKIP_ZERO_EN
            if (w != 64'd0)
`endif
            exp_q.push_back('{a: (base & ~64'h7) + 64'(8 * k), d: w});
        end
    endtask

    task automatic start_run(input logic [63:0] base, input int fstall, input int mstall);
        first_stall = fstall;
        max_stall   = mstall;
        run_id++;
        @(negedge clk);
        base_addr  = base;
        start      = 1'b1;
        accept_cyc = cyc;
    endtask

    task automatic run_dump(input logic [63:0] base, input int fstall, input int mstall, input int restart_at);
        bit finished;
        push_expected(base);
        exp_done.push_back(1);
        start_run(base, fstall, mstall);
        finished = 0;
        for (int i = 1; i < 600 && !finished; i++) begin
            @(negedge clk);
            start = (i == restart_at);
            #2;
            if (!busy) finished = 1;
        end
        start = 1'b0;
        if (!finished) check("run_timeout", 64'd0, 64'd1);
    endtask

    task automatic fill(input logic [EW-1:0] v);
        for (int r = 0; r < NR; r++) bht[r] = v;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = 64'd0;
        fill(6'h00);
        #23;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_row", 64'(row_addr), 64'd0);
        check("rst_bus", 64'(req == '0), 64'd1);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        fill(6'h3F);
        run_dump(64'h8000_1000, 0, 0, 0);
        run_dump(64'h8000_1000, 5, 0, 0);
        run_dump(64'h8000_1005, 0, 0, 0);
        run_dump(64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0);

        // Abort during the third gather cycle of word 1.
        fill(6'h2A);
        push_expected(64'h4000);
        void'(exp_q.pop_back());
        start_run(64'h4000, 0, 0);
        while (cyc < accept_cyc + 12) begin
            @(negedge clk);
            start = 1'b0;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #2;
        check("abort_busy", 64'(busy), 64'd0);
        repeat (20) @(negedge clk);
        fill(6'h15);
        run_dump(64'h4000, 0, 0, 0);

        // Start together with abort in IDLE is not accepted.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #2;
        check("start_abort_busy", 64'(busy), 64'd0);

        // Zero words in the lower half.
        for (int r = 0; r < NR; r++) bht[r] = (r < 8) ? 6'h00 : 6'h01;
        run_dump(64'h8000_2000, 0, 0, 0);

        // Random contents, bases, grant stalls and restart attempts while busy.
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < NW; k++) begin
                bit zw;
                zw = ($urandom_range(0, 2) == 0);
                for (int j = 0; j < 8; j++) bht[8*k + j] = zw ? 6'h00 : EW'($urandom);
            end
            run_dump({$urandom, $urandom}, $urandom_range(0, 3), 3, $urandom_range(2, 15));
        end

        // Reset in the middle of a run: no store, no done.
        fill(6'h3C);
        start_run(64'h9000, 0, 0);
        repeat (5) @(negedge clk);
        start = 1'b0;
        #1 rst_n = 1'b0;
        #1 check("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (15) @(negedge clk);

        check("left_stores", 64'(exp_q.size()), 64'd0);
        check("left_done", 64'(exp_done.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bht_ckpt_writer.md
# bht_ckpt_writer

- Sequencer that checkpoints the branch history table to memory. It sits downstream of `bht` and upstream of a D-cache store port.
- On a start request from the checkpoint CSR (0x808), it walks every BHT row through a combinational read port and packs 8 rows into each 64-bit doubleword.
- It issues one store per doubleword, starting at the CSR-supplied base address, then pulses `done_o` so the CSR can clear itself.

## Interface
Parameters:
- `NR_ROWS`, 512, number of BHT rows; power of two, multiple of 8, ≥ 8.
- `INSTR_PER_FETCH`, 2, entries per row; each entry is 3 bits {valid, ctr[1:0]}; INSTR_PER_FETCH*3 ≤ 8.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  checkpoint request (level or pulse); sampled only in IDLE.
- `abort_i`  in  1  flush; abandons the checkpoint and returns to IDLE.
- `base_addr_i`  in  64  destination base; bits [2:0] ignored (treated as 0); sampled on accept.
- `row_addr_o`  out  $clog2(NR_ROWS)  BHT row being read.
- `row_data_i`  in  INSTR_PER_FETCH*3  row contents, combinational from `row_addr_o`; entry i at bits [3i+2:3i].
- `dcache_req_o`  out  dcache_req_i_t  store request to the D-cache port.
- `dcache_gnt_i`  in  1  `data_gnt` of the port's dcache_req_o_t.
- `busy_o`  out  1  checkpoint in progress.
- `done_o`  out  1  one-cycle pulse on successful completion (drives `reset_checkpoint_o`).

## Operation
States: IDLE, GATHER, STORE, DONE.

- **IDLE**
  - `start_i`=1 and `abort_i`=0: latch `{base_addr_i[63:3],3'b0}` into addr_q, clear row_q and word_q, go to GATHER.
- **GATHER** (one row per cycle)
  - `row_addr_o` = row_q.
  - Byte (row_q mod 8) of word_q ← {zero pad, row_data_i}; row_q increments.
  - After byte 7 is written, go to STORE.
- **STORE**
  - `data_req`=1, `data_we`=1, `data_be`=8'hFF, `data_size`=2'b11, `data_wdata`=word_q.
  - `address_index` = addr_q[DCACHE_INDEX_WIDTH-1:0]; `address_tag` = addr_q[DCACHE_INDEX_WIDTH+DCACHE_TAG_WIDTH-1:DCACHE_INDEX_WIDTH].
  - `tag_valid`=0, `kill_req`=0.
  - All fields held stable until `dcache_gnt_i`=1.
  - On grant: addr_q += 8 (64-bit, wraps modulo 2^64), word_q ← 0.
  - Go to DONE if row_q wrapped to 0 (all NR_ROWS rows read), otherwise back to GATHER.
- **DONE**: `done_o`=1 for one cycle, then IDLE.
- **Bus idle**: outside STORE, every `dcache_req_o` field is 0.
- **Abort**: `abort_i` in any non-IDLE state → IDLE next cycle.
  - No `done_o`.
  - A request with no grant this cycle is dropped.
  - `abort_i` with a grant in the same cycle: the grant counts as the store completing, then IDLE.
- **Start + abort**: `start_i` and `abort_i` together in IDLE → stay in IDLE.
- **Start while busy**: ignored; no queueing.
- **Words per checkpoint**: NR_ROWS/8 (64 at default). Word k is written to base + 8k.

## Timing
- **Reset values**
  - `busy_o`=0, `done_o`=0, `row_addr_o`=0, all `dcache_req_o` fields 0, state IDLE.
  - Reset mid-operation returns to IDLE immediately; no partial `done_o`.
- **Accept**: start accepted in cycle 0 → `busy_o`=1 and GATHER from cycle 1; `busy_o` stays high through the DONE cycle.
- **Per word**: 8 GATHER cycles, then STORE for ≥ 1 cycle (1 + grant wait).
- **Total** with immediate grant: (NR_ROWS/8)·9 + 1 cycles from accept to `done_o`; 577 at default.
- **Return to IDLE**: `done_o` asserts the cycle after the final grant. The block returns to IDLE the following cycle and can accept a new start then.
- **Read port**: `row_data_i` is sampled in the same cycle `row_addr_o` is driven; no read latency.

## Configuration
- **`BHT_CKPT_SKIP_ZERO_EN`** defined:
  - At STORE entry, if word_q == 0, no request is issued.
  - addr_q still advances by 8 and the FSM continues as if granted; this takes 1 cycle in STORE.
  - Memory for that word is left untouched.
- **Undefined**: every word is stored, including all-zero words.

## Test plan
- **Basic dump**: NR_ROWS=16, rows 0–15 = 6'h3F, base 0x8000_1000, gnt tied 1.
  - Exactly 2 stores: 0x8000_1000 and 0x8000_1008, each wdata 64'h3F3F3F3F3F3F3F3F.
  - `done_o` one cycle, 19 cycles after accept.
- **Grant backpressure**: gnt held 0 for 5 cycles on the first store.
  - Request fields stable throughout; same addresses and data as the basic dump.
  - `done_o` 5 cycles later.
- **Unaligned base**: base 0x8000_1005 → first store at 0x8000_1000.
- **Address wrap**: base 0xFFFF_FFFF_FFFF_FFF8, NR_ROWS=16 → stores at 0xFFFF_FFFF_FFFF_FFF8 then 0x0.
- **Abort**: `abort_i` during the 3rd GATHER cycle of word 1.
  - `busy_o` low next cycle; no further requests; `done_o` never asserted.
  - A new start afterwards restarts at row 0.
- **Zero skip**: rows 0–7 zero, rows 8–15 = 6'h01.
  - With `BHT_CKPT_SKIP_ZERO_EN`: one store at base+8, wdata 64'h0101010101010101.
  - Without it: two stores, the first with wdata 0.
